// File: rtl/csa_pkg.sv
// Shared constants and elaboration helpers for the pipelined conditional-sum adder.
package csa_pkg;

    localparam int DEFAULT_WIDTH           = 32;
    localparam int DEFAULT_UNIT            = 4;
    localparam int DEFAULT_UNITS_PER_STAGE = 2;

    // Operation selected by the 'sub' input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of pipeline stages, each covering UNIT*UNITS_PER_STAGE result bits.
    function automatic int calc_stages(input int width, input int unit, input int units_per_stage);
        return width / (unit * units_per_stage);
    endfunction

    // The operand must split into whole stages, otherwise the top bits would be dropped.
    function automatic bit width_ok(input int width, input int unit, input int units_per_stage);
        return (unit > 0) && (units_per_stage > 0) && ((width % (unit * units_per_stage)) == 0);
    endfunction

endpackage

// File: rtl/csa_slice.sv
// Combinational conditional-sum slice: both carry-in cases are formed up front and the
// incoming carry only drives the final select, keeping it off the adder's internal path.
module csa_slice #(
    parameter int UNIT = 4
) (
    input  logic [UNIT-1:0] a,
    input  logic [UNIT-1:0] b,
    input  logic            ci,
    output logic [UNIT-1:0] s,
    output logic            co
);

    logic [UNIT:0] sum_c0;
    logic [UNIT:0] sum_c1;

    // Precompute carry-in 0 and 1 results, then pick one with ci.
    always_comb begin
        // NOTE: every output of a combinational block is fully assigned on every path, so no latch is inferred.
        sum_c0  = {1'b0, a} + {1'b0, b};
        sum_c1  = {1'b0, a} + {1'b0, b} + {{UNIT{1'b0}}, 1'b1};
        {co, s} = ci ? sum_c1 : sum_c0;
    end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined conditional-sum adder/subtractor with a valid/ready handshake.
// Stage k adds bit group [k*G +: G]; operands travel forward skewed and the finished
// low result bits travel forward with them, so the last stage holds the full result.
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int UNIT            = DEFAULT_UNIT,
    parameter int UNITS_PER_STAGE = DEFAULT_UNITS_PER_STAGE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int G      = UNIT * UNITS_PER_STAGE;
    localparam int STAGES = calc_stages(WIDTH, UNIT, UNITS_PER_STAGE);

    if (!width_ok(WIDTH, UNIT, UNITS_PER_STAGE)) begin : g_bad_width
        $error("csa_pipe_adder: WIDTH must be a multiple of UNIT*UNITS_PER_STAGE");
    end

    op_e op;
    assign op = op_e'(sub);

    // Inputs seen by each stage this cycle (ports for stage 0, previous stage's flops otherwise).
    logic [WIDTH-1:0]  a_in   [STAGES];
    logic [WIDTH-1:0]  b_in   [STAGES];
    logic [WIDTH-1:0]  sum_in [STAGES];
    logic [STAGES-1:0] cin;
    logic [STAGES-1:0] valid_in;

    // Stage registers.
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] valid_q;
    logic              ovf_d;
    logic              ovf_q;

    // Per-stage arithmetic results; stage k owns bits [k*G +: G] of stage_res.
    logic [WIDTH-1:0]  stage_res;
    logic [STAGES-1:0] stage_co;
    logic [STAGES-1:0] ready;

    // Route ports into stage 0 and each stage's flops into the next stage.
    always_comb begin
        a_in[0]     = a;
        b_in[0]     = (op == OP_SUB) ? ~b : b;
        cin         = '0;
        cin[0]      = (op == OP_SUB) ? 1'b1 : ci;
        sum_in[0]   = '0;
        valid_in    = '0;
        valid_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]     = a_q[k-1];
            b_in[k]     = b_q[k-1];
            sum_in[k]   = sum_q[k-1];
            cin[k]      = carry_q[k-1];
            valid_in[k] = valid_q[k-1];
        end
    end

    // Backpressure: ready_k = !valid_k || ready_{k+1}, unrolled so each bit depends only on valid flops.
    always_comb begin
        ready = '0;
        for (int k = 0; k < STAGES; k++) begin
            ready[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!valid_q[j]) begin
                    ready[k] = 1'b1;
                end
            end
        end
    end

    // Slice chain of each stage: slice u takes its carry from slice u-1, slice 0 from the stage carry in.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        for (genvar u = 0; u < UNITS_PER_STAGE; u++) begin : g_slice
            logic c_in;
            logic c_out;
            if (u == 0) begin : g_first
                assign c_in = cin[k];
            end else begin : g_next
                assign c_in = g_slice[u-1].c_out;
            end
            csa_slice #(.UNIT(UNIT)) u_slice (
                .a  (a_in[k][k*G + u*UNIT +: UNIT]),
                .b  (b_in[k][k*G + u*UNIT +: UNIT]),
                .ci (c_in),
                .s  (stage_res[k*G + u*UNIT +: UNIT]),
                .co (c_out)
            );
        end
        assign stage_co[k] = g_slice[UNITS_PER_STAGE-1].c_out;
    end

    // Next state: a ready stage loads from upstream (bubbles included), a stalled stage holds.
    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
            if (ready[k]) begin
                valid_d[k]             = valid_in[k];
                a_d[k]                 = a_in[k];
                b_d[k]                 = b_in[k];
                sum_d[k]               = sum_in[k];
                sum_d[k][k*G +: G]     = stage_res[k*G +: G];
                carry_d[k]             = stage_co[k];
            end
        end
        // Carry into the MSB is a^b^s at that bit; overflow is it XOR the final carry out.
        if (ready[STAGES-1]) begin
            ovf_d = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
                  ^ stage_res[WIDTH-1] ^ stage_co[STAGES-1];
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data registers are cleared as well as valids, so outputs read zero straight after reset.
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the pre-edge values of its neighbour.
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign s         = sum_q[STAGES-1];
    assign co        = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
- Parametrised, pipelined conditional-sum adder/subtractor.
- Built from UNIT-bit conditional-sum slices. Each slice precomputes both carry-in cases and selects with the incoming carry.
- A pipeline register is placed after every UNITS_PER_STAGE slices. Operands enter over a valid/ready handshake, and results leave with signed-overflow reporting.
- Sits in the datapath as a drop-in wide adder wherever timing forbids a single-cycle ripple or carry-select chain.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of UNIT*UNITS_PER_STAGE.
- UNIT, 4, bits per conditional-sum slice.
- UNITS_PER_STAGE, 2, slices evaluated per pipeline stage.
- Derived: STAGES = WIDTH/(UNIT*UNITS_PER_STAGE). STAGES is 4 at the defaults.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, block accepts operands this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- ci, input, 1, carry in; ignored when sub=1.
- sub, input, 1, 0: a+b+ci; 1: a-b computed as a+~b+1.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- s, output, WIDTH, sum/difference.
- co, output, 1, carry out of MSB. For sub, co=1 means no borrow.
- ovf, output, 1, two's-complement overflow.

Behaviour:
- Reset: rst_n=0 sampled at a clk edge clears every stage valid bit and every data/carry register.
  - After reset, out_valid=0, s=0, co=0, ovf=0.
  - in_ready is combinational and therefore 1 after reset.
- Reset mid-operation discards all in-flight items. No partial result is ever presented.
- Transfer rules: input transfer happens when in_valid && in_ready; output transfer happens when out_valid && out_ready.
- Pipeline: STAGES registered stages, so latency is exactly STAGES cycles from input transfer to out_valid, given no stall. At the defaults an item accepted at edge N is presented after edge N+3 (4 stages).
- Stage k (k=0..STAGES-1):
  - Adds operand bits [k*G +: G], where G = UNIT*UNITS_PER_STAGE.
  - Carry in is the registered carry from stage k-1; stage 0 uses cin = sub ? 1 : ci.
  - Inside the stage, slices chain by selecting between precomputed carry-0 and carry-1 results.
  - Stage k registers its G result bits and carry out. It also forwards the already-computed lower result bits and the not-yet-consumed upper operand bits, so operands are skewed and results de-skewed.
  - sub-inverted B is formed at stage 0 and carried forward.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Flow control: each stage has a valid bit.
  - ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready. in_ready = ready_0.
  - A stage loads when ready_k is 1. A stalled stage holds data and valid unchanged.
  - Full throughput is 1 item/cycle when out_ready stays 1. Bubbles do not block later items.
- out_valid=1 with out_ready=0: s/co/ovf stay stable until the transfer.
- Simultaneous output transfer and input acceptance when full: allowed; no loss and no duplication.
- in_valid=0 cycles insert bubbles, which propagate with valid=0.
- Wrap-around: results are modulo 2^WIDTH; co and ovf report the overflow.

Decomposition:
- Package csa_pkg:
  - default WIDTH/UNIT/UNITS_PER_STAGE constants;
  - a function computing STAGES;
  - an elaboration check that WIDTH % (UNIT*UNITS_PER_STAGE) == 0.
- Sub-module csa_slice #(UNIT): combinational conditional-sum slice.
  - Ports: a, b, ci, s, co.
  - Computes both carry-in results internally and selects by ci.
  - Instantiated UNITS_PER_STAGE times per stage via generate.

Test Plan (defaults, out_ready=1 unless stated):
- Carry through all stages: a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0 -> 4 cycles later s=0x00000000, co=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, ovf=1. Also ci=1 on a=0x00000010, b=0x00000020 -> s=0x00000031, co=0, ovf=0.
- Subtract: a=5, b=7, sub=1, ci=1 (ignored) -> s=0xFFFFFFFE, co=0, ovf=0. Also a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, co=1, ovf=1.
- Back-to-back stream and stall:
  - Stimulus: 8 consecutive items a=i, b=i (i=0..7) with out_ready held 0 from cycle 2 to cycle 6.
  - Required response: results 0,2,..,14 emerge in order with none lost or duplicated.
  - in_ready drops to 0 once all 4 stages hold valid items; outputs stay stable while stalled.
- Bubbles: items with in_valid 1,0,1 -> out_valid pattern 1,0,1 with latency 4 each.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 items in flight -> next cycle out_valid=0, s=0, co=0, ovf=0, in_ready=1. No stale result appears afterwards.
